// File: rtl/ram_port_arbiter.sv
// Shares the single-port 4096x16 RAM between the CPU (port 0) and a secondary master (port 1).
// Fixed CPU priority with a port-1 starvation guard, lockable ownership and per-port read return.
module ram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [11:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic        p0_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [11:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] p1_rdata,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic [1:0]  dbg_owner,
  output logic [7:0]  dbg_wait1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [1:0] ownerReg, ownerNext;
  logic [7:0] wait1Reg, wait1Next;
  logic       rdP0Reg, rdP1Reg;
  logic       gnt0, gnt1;

  // Grants are suppressed for the whole time reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (ownerReg)
        OWN0: gnt0 = p0_req;
        OWN1: gnt1 = p1_req;
        default: begin
          if (p0_req && p1_req) begin
            if (wait1Reg == LIMIT) gnt1 = 1'b1;
            else                   gnt0 = 1'b1;
          end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    ownerNext = ownerReg;
    case (ownerReg)
      OWN0: if (!p0_lock) ownerNext = IDLE;
      OWN1: if (!p1_lock) ownerNext = IDLE;
      default: begin
        ownerNext = IDLE;
        if (gnt0 && p0_lock)      ownerNext = OWN0;
        else if (gnt1 && p1_lock) ownerNext = OWN1;
      end
    endcase
  end

  always_comb begin
    wait1Next = wait1Reg;
    if (gnt1)                            wait1Next = 8'd0;
    else if (p1_req && wait1Reg < LIMIT) wait1Next = wait1Reg + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerReg <= IDLE;
      wait1Reg <= 8'd0;
      rdP0Reg  <= 1'b0;
      rdP1Reg  <= 1'b0;
    end else begin
      ownerReg <= ownerNext;
      wait1Reg <= wait1Next;
      rdP0Reg  <= gnt0 & ~p0_we;
      rdP1Reg  <= gnt1 & ~p1_we;
    end
  end

  // Port 0 drives the address/data bus whenever port 1 is not granted.
  assign mem_we   = (gnt0 & p0_we) | (gnt1 & p1_we);
  assign mem_addr = gnt1 ? p1_addr  : p0_addr;
  assign mem_din  = gnt1 ? p1_wdata : p0_wdata;

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = rdP0Reg;
  assign p1_rvalid = rdP1Reg;
  assign p0_rdata  = mem_dout;
  assign p1_rdata  = mem_dout;
  assign dbg_owner = ownerReg;
  assign dbg_wait1 = wait1Reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vectors, hand sequences and random traffic
// checked against a rule-level model, with a behavioural 1-cycle-latency RAM attached.
module tb_ram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [11:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic [1:0]  dbg_owner;
  logic [7:0]  dbg_wait1;

  always #5 clk = ~clk;

  ram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_owner(dbg_owner), .dbg_wait1(dbg_wait1)
  );

  // Behavioural single-port RAM with registered read.
  logic [15:0] ram [4096];
  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int total = 0;
  int bad = 0;
  int cycN = 0;

  // Reference model state: who holds the lock, how long port 1 has waited,
  // which port expects read data this cycle and what that data is.
  int          mOwner = 0;
  int          mWait = 0;
  bit          mRv0 = 0, mRv1 = 0;
  logic [15:0] mRdata = '0;
  logic [15:0] refMem [4096];

  logic        obsG0, obsG1, obsWe, obsRv0, obsRv1;
  logic [15:0] obsRd0, obsRd1;
  logic [1:0]  obsOwner;
  logic [7:0]  obsWait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycN, act, exp);
    end
  endtask

  task automatic cyc(input logic r,
                     input logic q0, input logic w0, input logic l0,
                     input logic [11:0] a0, input logic [15:0] d0,
                     input logic q1, input logic w1, input logic l1,
                     input logic [11:0] a1, input logic [15:0] d1);
    bit eg0, eg1;
    rst = r;
    p0_req = q0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = q1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    #1;
    if (r) begin
      mOwner = 0; mWait = 0; mRv0 = 0; mRv1 = 0;
    end
    eg0 = 0; eg1 = 0;
    if (!r) begin
      if (mOwner == 1)      eg0 = q0;
      else if (mOwner == 2) eg1 = q1;
      else if (q0 && q1) begin
        eg1 = (mWait == LIMIT);
        eg0 = !eg1;
      end else begin
        eg0 = q0; eg1 = q1;
      end
    end
    chk("p0_gnt", p0_gnt, eg0);
    chk("p1_gnt", p1_gnt, eg1);
    chk("mem_we", mem_we, (eg0 && w0) || (eg1 && w1));
    if (eg0 || eg1) chk("mem_addr", mem_addr, eg1 ? a1 : a0);
    if ((eg0 && w0) || (eg1 && w1)) chk("mem_din", mem_din, eg1 ? d1 : d0);
    chk("p0_rvalid", p0_rvalid, mRv0);
    chk("p1_rvalid", p1_rvalid, mRv1);
    if (mRv0) chk("p0_rdata", p0_rdata, mRdata);
    if (mRv1) chk("p1_rdata", p1_rdata, mRdata);
    chk("dbg_owner", dbg_owner, mOwner);
    chk("dbg_wait1", dbg_wait1, mWait);
    obsG0 = p0_gnt; obsG1 = p1_gnt; obsWe = mem_we;
    obsRv0 = p0_rvalid; obsRv1 = p1_rvalid;
    obsRd0 = p0_rdata; obsRd1 = p1_rdata;
    obsOwner = dbg_owner; obsWait = dbg_wait1;
    $display("cyc %0d rst=%b g0=%b g1=%b we=%b addr=%h rv0=%b rv1=%b rd=%h own=%0d wait=%0d",
             cycN, r, p0_gnt, p1_gnt, mem_we, mem_addr, p0_rvalid, p1_rvalid, p0_rdata,
             dbg_owner, dbg_wait1);
    if (!r) begin
      mRv0 = eg0 && !w0;
      mRv1 = eg1 && !w1;
      if (eg0 || eg1) mRdata = refMem[eg1 ? a1 : a0];
      if (eg0 && w0) refMem[a0] = d0;
      if (eg1 && w1) refMem[a1] = d1;
      if (mOwner == 0) begin
        if (eg0 && l0)      mOwner = 1;
        else if (eg1 && l1) mOwner = 2;
      end else if (mOwner == 1 && !l0) mOwner = 0;
      else if (mOwner == 2 && !l1) mOwner = 0;
      if (eg1)                       mWait = 0;
      else if (q1 && mWait < LIMIT)  mWait = mWait + 1;
    end
    cycN++;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 12'h0, 16'h0, 0, 0, 0, 12'h0, 16'h0);
  endtask

  typedef struct {
    logic        q0, w0, q1, w1;
    logic [11:0] a0, a1;
    logic [15:0] d0, d1;
    logic        eg0, eg1;
    logic [7:0]  ew;
  } vec_t;

  vec_t vt [12];

  initial begin
    // Both ports writing continuously: the starvation guard lets port 1 in every 5th cycle.
    vt[0]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA000, 16'hB000, 1, 0, 8'd0};
    vt[1]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA001, 16'hB001, 1, 0, 8'd1};
    vt[2]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA002, 16'hB002, 1, 0, 8'd2};
    vt[3]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA003, 16'hB003, 1, 0, 8'd3};
    vt[4]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA004, 16'hB004, 0, 1, 8'd4};
    vt[5]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA005, 16'hB005, 1, 0, 8'd0};
    vt[6]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA006, 16'hB006, 1, 0, 8'd1};
    vt[7]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA007, 16'hB007, 1, 0, 8'd2};
    vt[8]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA008, 16'hB008, 1, 0, 8'd3};
    vt[9]  = '{1, 1, 1, 1, 12'h100, 12'h101, 16'hA009, 16'hB009, 0, 1, 8'd4};
    vt[10] = '{0, 0, 1, 1, 12'h100, 12'h101, 16'hA00A, 16'hB00A, 0, 1, 8'd0};
    vt[11] = '{1, 1, 0, 0, 12'h100, 12'h101, 16'hA00B, 16'hB00B, 1, 0, 8'd0};

    // Reset held with both ports requesting.
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 1, 12'h005, 16'h5555, 1, 1, 1, 12'h006, 16'h6666);
      chk("rst_g0", obsG0, 0);
      chk("rst_g1", obsG1, 0);
      chk("rst_we", obsWe, 0);
      chk("rst_rv0", obsRv0, 0);
      chk("rst_rv1", obsRv1, 0);
      chk("rst_owner", obsOwner, 0);
      chk("rst_wait", obsWait, 0);
    end

    foreach (vt[i]) begin
      cyc(0, vt[i].q0, vt[i].w0, 0, vt[i].a0, vt[i].d0, vt[i].q1, vt[i].w1, 0, vt[i].a1, vt[i].d1);
      chk("vec_g0", obsG0, vt[i].eg0);
      chk("vec_g1", obsG1, vt[i].eg1);
      chk("vec_wait", obsWait, vt[i].ew);
    end

    // Preload the address window used by the random traffic.
    for (int a = 0; a < 16; a++)
      cyc(0, 1, 1, 0, 12'(a), 16'($urandom), 0, 0, 0, 12'h0, 16'h0);

    // Port 0 write then read-back.
    cyc(0, 1, 1, 0, 12'h010, 16'hBEEF, 0, 0, 0, 12'h0, 16'h0);
    chk("wr_g0", obsG0, 1);
    cyc(0, 1, 0, 0, 12'h010, 16'h0, 0, 0, 0, 12'h0, 16'h0);
    chk("rd_g0", obsG0, 1);
    idle();
    chk("rd_rv0", obsRv0, 1);
    chk("rd_data", obsRd0, 16'hBEEF);
    chk("rd_rv1", obsRv1, 0);

    // Locked read-modify-write by port 1 while port 0 waits.
    cyc(0, 0, 0, 0, 12'h0, 16'h0, 1, 1, 0, 12'h020, 16'h1234);
    cyc(0, 0, 0, 0, 12'h0, 16'h0, 1, 0, 1, 12'h020, 16'h0);
    chk("lk_g1a", obsG1, 1);
    cyc(0, 1, 0, 0, 12'h020, 16'h0, 1, 1, 1, 12'h020, 16'h1235);
    chk("lk_owner", obsOwner, 2);
    chk("lk_g0", obsG0, 0);
    chk("lk_g1b", obsG1, 1);
    chk("lk_wait", obsWait, 0);
    chk("lk_rv1", obsRv1, 1);
    chk("lk_rd1", obsRd1, 16'h1234);
    cyc(0, 1, 0, 0, 12'h020, 16'h0, 0, 0, 0, 12'h0, 16'h0);
    chk("lk_owner2", obsOwner, 2);
    chk("lk_g0b", obsG0, 0);
    chk("lk_wait2", obsWait, 0);
    cyc(0, 1, 0, 0, 12'h020, 16'h0, 0, 0, 0, 12'h0, 16'h0);
    chk("ul_owner", obsOwner, 0);
    chk("ul_g0", obsG0, 1);
    idle();
    chk("ul_rv0", obsRv0, 1);
    chk("ul_rd0", obsRd0, 16'h1235);

    // Reset in the cycle after a locked port-0 read grant.
    cyc(0, 1, 0, 1, 12'h010, 16'h0, 0, 0, 0, 12'h0, 16'h0);
    chk("mr_g0", obsG0, 1);
    cyc(1, 0, 0, 1, 12'h0, 16'h0, 0, 0, 0, 12'h0, 16'h0);
    chk("mr_rv0", obsRv0, 0);
    chk("mr_owner", obsOwner, 0);
    idle();
    chk("mr_owner2", obsOwner, 0);
    chk("mr_rv0b", obsRv0, 0);

    // Alternating reads return on consecutive cycles.
    cyc(0, 1, 1, 0, 12'h001, 16'h1111, 0, 0, 0, 12'h0, 16'h0);
    cyc(0, 0, 0, 0, 12'h0, 16'h0, 1, 1, 0, 12'h002, 16'h2222);
    cyc(0, 1, 0, 0, 12'h001, 16'h0, 0, 0, 0, 12'h0, 16'h0);
    cyc(0, 0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 12'h002, 16'h0);
    chk("alt_rv0", obsRv0, 1);
    chk("alt_rd0", obsRd0, 16'h1111);
    chk("alt_rv1a", obsRv1, 0);
    idle();
    chk("alt_rv1", obsRv1, 1);
    chk("alt_rd1", obsRd1, 16'h2222);
    chk("alt_rv0b", obsRv0, 0);

    // Random traffic within the preloaded window.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 63) == 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
          12'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
          12'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port arbiter that shares the single-port 4096x16 `ram_16bit` between the CPU memory port (port 0) and a secondary bus master such as a DMA or I/O engine (port 1). It sits between `yildiz_cpu_16bit` / the secondary master and the RAM instance inside the top level. It applies fixed CPU priority with a starvation guard for port 1, and supports a lock for atomic read-modify-write sequences. It routes the one-cycle-latency read data back to the requester that issued the read.

## Interface
- `STARVE_LIMIT`, default 4 (legal range 1..255): the number of consecutive denied cycles after which port 1 overrides port 0.
- `clk`  in  1  the single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request; held with addr/we/wdata until the matching `gnt`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  12  word address.
- `p0_wdata`, `p1_wdata`  in  16  write data.
- `p0_lock`, `p1_lock`  in  1  request or keep exclusive ownership.
- `p0_gnt`, `p1_gnt`  out  1  combinational; the access executes in this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  registered; read data is valid this cycle.
- `p0_rdata`, `p1_rdata`  out  16  both driven by `mem_dout`; qualified by the matching rvalid.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  12  RAM address.
- `mem_din`  out  16  RAM write data.
- `mem_dout`  in  16  RAM read data, registered inside the RAM with 1-cycle latency.
- `dbg_owner`  out  2  0 = IDLE, 1 = OWN0, 2 = OWN1.
- `dbg_wait1`  out  8  port-1 starvation counter.

## Operation
- **Lock state machine.** States are IDLE, OWN0 and OWN1.
  - IDLE → OWNn: port n is granted in a cycle with `pn_lock` = 1.
  - OWNn → IDLE: at the edge following any cycle in which `pn_lock` = 0.
  - While in OWNn, only port n can be granted. The other port waits, even if its starvation counter is saturated.
- **Grant rules in IDLE.**
  - Only one port requesting: that port is granted.
  - Both ports requesting: port 1 wins if `wait1 == STARVE_LIMIT`; otherwise port 0 wins.
  - At most one gnt is high per cycle.
- **Starvation counter `wait1`.**
  - Increments at each edge where `p1_req` = 1 and `p1_gnt` = 0.
  - Saturates at `STARVE_LIMIT`.
  - Clears to 0 at an edge where `p1_gnt` = 1.
  - Holds its value when `p1_req` = 0.
- **Mux.** `mem_addr`, `mem_din` and `mem_we` come from the granted port, with `mem_we = gnt & we`. With no grant: `mem_we` = 0, and `mem_addr`/`mem_din` are driven from port 0 (don't-care).
- **Read return.** On a granted read, a registered flag `rd_pn` is set for one cycle. `pn_rvalid = rd_pn`.
- **Writes.** No rvalid is raised for a write.
- **Back-to-back reads.** Reads from alternating ports each return on the cycle after their own grant, with no bubble.
- **Reset.**
  - State returns to IDLE; `wait1` = 0; both rvalid = 0.
  - While `rst` is high, all gnt outputs and `mem_we` are forced to 0.
  - Reset asserted mid-operation discards any pending rvalid and releases any lock.

## Timing
- Grant is combinational in the request cycle. Minimum access is 1 cycle, and a port can be granted every cycle.
- Read latency: data and rvalid appear at grant cycle + 1.
- Write latency: the write commits at the edge that ends the grant cycle.
- A lock asserted with the first access takes effect from the next cycle.
- Maximum wait for port 1 outside lock: `STARVE_LIMIT` cycles.
- Reset values:
  - `p0_gnt`, `p1_gnt`, `p0_rvalid`, `p1_rvalid`, `mem_we` = 0.
  - `dbg_owner` = 0, `dbg_wait1` = 0.
  - `p0_rdata`/`p1_rdata` follow `mem_dout`.

## Test plan
1. **Reset.** Hold `rst` = 1 with both req = 1 → both gnt = 0, `mem_we` = 0, both rvalid = 0, `dbg_owner` = 0, `dbg_wait1` = 0.
2. **Write then read, port 0.** p0 writes 0xBEEF to 0x010, then reads 0x010 → `p0_gnt` = 1 in each request cycle; `p0_rvalid` = 1 with `p0_rdata` = 0xBEEF one cycle after the read grant; `p1_rvalid` stays 0.
3. **Starvation guard.** With `STARVE_LIMIT` = 4, both ports request every cycle → p0 is granted in cycles 0–3 and p1 in cycle 4, with `dbg_wait1` counting 0,1,2,3,4,0. The 5-cycle pattern repeats.
4. **Lock.** p1 reads 0x020 (holding 0x1234) with `p1_lock` = 1, then writes 0x1235 while p0 requests → `dbg_owner` = 2, `p0_gnt` = 0 throughout, `dbg_wait1` stays 0. Then p1 drops lock → p0 is granted the cycle after; a read of 0x020 by p0 returns 0x1235.
5. **Reset mid-operation.** Assert `rst` in the cycle after a p0 read grant → `p0_rvalid` = 0 immediately; state is IDLE after release.
6. **Alternating reads.** p0 reads 0x001 in cycle N and p1 reads 0x002 in cycle N+1 → `p0_rvalid` at N+1 and `p1_rvalid` at N+2, each with the correct data.
